riscv_pc_alu_dmem: RTL and testbench

//  Execute/memory slice of the single-cycle RV32I core: program counter, 32-bit integer ALU and word data memory.
//  The control/decode logic in the core top drives the PC step, ALU op/operands and memory strobes.
//  The top muxes ALUout and read_data into register writeback.
//  The PC addresses instruction memory.

---
 rtl/riscv_pc_alu_dmem.sv | 103 ++++++++++
 tb/tb_riscv_pc_alu_dmem.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_pc_alu_dmem.sv
// Execute/memory slice of the single-cycle RV32I core: program counter,
// 32-bit integer ALU and word-organised data memory.
module riscv_pc_alu_dmem #(
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcnext,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic [31:0] pc_reg,
  input  logic [3:0]  ALUctl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] ALUout,
  output logic        zero,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  logic [31:0] pc_q, pc_d;
  logic [31:0] alu_d;
  logic [AW-1:0] idx;
  // Contents survive reset; they start at zero only at power-up.
  logic [31:0] mem_q [MEM_WORDS] = '{default: '0};

  // Byte-address bits below the word and above the memory depth are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:AW+2], address[1:0], pc_target[1:0]};

  assign idx = address[AW+1:2];

  // Next PC: a load wins over a step; targets are forced word-aligned.
  always_comb begin
    pc_d = pc_q;
    if (pc_load) begin
      pc_d = {pc_target[31:2], 2'b00};
    end else if (pcnext) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // PC register, forced to PC_RESET as soon as reset drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_reg = pc_q;

  // Zero-latency ALU; unused encodings yield 0.
  always_comb begin
    alu_d = 32'h0;
    unique case (ALUctl)
      OP_ADD:  alu_d = A + B;
      OP_SLL:  alu_d = A << B[4:0];
      OP_SLT:  alu_d = {31'b0, $signed(A) < $signed(B)};
      OP_SLTU: alu_d = {31'b0, A < B};
      OP_XOR:  alu_d = A ^ B;
      OP_SRL:  alu_d = A >> B[4:0];
      OP_OR:   alu_d = A | B;
      OP_AND:  alu_d = A & B;
      OP_SUB:  alu_d = A - B;
      OP_SRA:  alu_d = $unsigned($signed(A) >>> B[4:0]);
      default: alu_d = 32'h0;
    endcase
  end

  assign ALUout = alu_d;
  assign zero   = (alu_d == 32'h0);

  // Synchronous word write; stores are blocked while reset is held low.
  always_ff @(posedge clk) begin
    if (reset && write_enable) begin
      mem_q[idx] <= write_data;
    end
  end

  // Combinational read, so a same-edge write shows old data until the edge.
  assign read_data = (reset && read_enable) ? mem_q[idx] : 32'h0;

endmodule

// File: tb/tb_riscv_pc_alu_dmem.sv
// Self-checking bench for riscv_pc_alu_dmem: directed cases plus randomised
// ALU, PC and memory traffic checked against a behavioural model.
module tb_riscv_pc_alu_dmem;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcnext;
  logic        pc_load;
  logic [31:0] pc_target;
  logic [31:0] pc_reg;
  logic [3:0]  ALUctl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ALUout;
  logic        zero;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  int passed = 0;
  int total  = 0;

  logic [31:0] mem_m [256];
  logic [31:0] pc_m;

  riscv_pc_alu_dmem dut (
    .clk          (clk),
    .reset        (reset),
    .pcnext       (pcnext),
    .pc_load      (pc_load),
    .pc_target    (pc_target),
    .pc_reg       (pc_reg),
    .ALUctl       (ALUctl),
    .A            (A),
    .B            (B),
    .ALUout       (ALUout),
    .zero         (zero),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU from the instruction-set definitions.
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic [31:0] r;
    sh = b % 32;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a * (32'd1 << sh);
      4'd2:  r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd3:  r = (a < b) ? 32'd1 : 32'd0;
      4'd4:  r = a ^ b;
      4'd5:  r = a / (32'd1 << sh);
      4'd6:  r = a | b;
      4'd7:  r = a & b;
      4'd8:  r = a + (~b + 32'd1);
      4'd13: r = (a / (32'd1 << sh)) | ((a[31] && sh != 0) ? ~(32'hFFFF_FFFF / (32'd1 << sh)) : 32'd0);
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic alu_check(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
    ALUctl = op; A = a; B = b;
    #1;
    check(tag, ALUout, exp);
    check({tag, "_zero"}, {31'b0, zero}, {31'b0, exp == 32'd0});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
    reset = 1'b0; pcnext = 1'b0; pc_load = 1'b0; pc_target = 32'h0;
    ALUctl = 4'd0; A = 32'h0; B = 32'h0;
    write_enable = 1'b0; read_enable = 1'b1; address = 32'h0; write_data = 32'h0;
    #12;
    check("reset_pc", pc_reg, 32'h0);
    check("reset_rd", read_data, 32'h0);
    reset = 1'b1;
    read_enable = 1'b0;
    step();

    // PC stepping, load alignment and wrap
    pcnext = 1'b1;
    step(); check("pc_step1", pc_reg, 32'd4);
    step(); check("pc_step2", pc_reg, 32'd8);
    step(); check("pc_step3", pc_reg, 32'd12);
    pc_load = 1'b1; pc_target = 32'h103;
    step(); check("pc_load_align", pc_reg, 32'h100);
    pc_target = 32'hFFFF_FFFC;
    step(); check("pc_load_top", pc_reg, 32'hFFFF_FFFC);
    pc_load = 1'b0;
    step(); check("pc_wrap", pc_reg, 32'h0);

    // Asynchronous reset mid-cycle
    pc_load = 1'b1; pc_target = 32'h40; pcnext = 1'b0;
    step(); check("pc_at_40", pc_reg, 32'h40);
    pc_load = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("pc_async_reset", pc_reg, 32'h0);
    step();
    reset = 1'b1;
    step(); step();
    check("pc_hold_after_reset", pc_reg, 32'h0);

    // Directed ALU vectors
    alu_check("add",  4'd0,  32'd7,        32'd5,   32'd12);
    alu_check("sub",  4'd8,  32'd5,        32'd5,   32'd0);
    alu_check("slt",  4'd2,  32'hFFFF_FFFF, 32'd1,  32'd1);
    alu_check("sltu", 4'd3,  32'hFFFF_FFFF, 32'd1,  32'd0);
    alu_check("sra",  4'd13, 32'h8000_0000, 32'd4,  32'hF800_0000);
    alu_check("srl",  4'd5,  32'h8000_0000, 32'd4,  32'h0800_0000);
    alu_check("sll",  4'd1,  32'd1,        32'd33,  32'd2);
    alu_check("xor",  4'd4,  32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000);
    alu_check("or",   4'd6,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
    alu_check("and",  4'd7,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    alu_check("undef",4'd9,  32'd3,        32'd4,   32'd0);

    // Randomised ALU against the reference
    for (int i = 0; i < 200; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom;
      if (i % 8 == 0) b = a;
      alu_check($sformatf("alu_rand_op%0d", op), op, a, b, alu_ref(op, a, b));
    end

    // Memory basics
    write_enable = 1'b1; address = 32'h10; write_data = 32'hDEAD_BEEF;
    step(); mem_m[4] = 32'hDEAD_BEEF;
    write_enable = 1'b0; read_enable = 1'b1;
    #1; check("mem_rd_10", read_data, 32'hDEAD_BEEF);
    address = 32'h13;
    #1; check("mem_rd_13", read_data, 32'hDEAD_BEEF);
    read_enable = 1'b0;
    #1; check("mem_rd_disabled", read_data, 32'h0);

    // Index wraps modulo depth
    write_enable = 1'b1; address = 32'h400; write_data = 32'h55;
    step(); mem_m[0] = 32'h55;
    write_enable = 1'b0; read_enable = 1'b1; address = 32'h0;
    #1; check("mem_wrap", read_data, 32'h55);
    address = 32'h44;
    #1; check("mem_unwritten", read_data, 32'h0);

    // Same-edge read and write
    write_enable = 1'b1; address = 32'h20; write_data = 32'h1;
    step();
    write_data = 32'h2;
    #1; check("rw_before_edge", read_data, 32'h1);
    step(); mem_m[8] = 32'h2;
    check("rw_after_edge", read_data, 32'h2);

    // Writes are ignored while reset is held
    write_data = 32'h99;
    reset = 1'b0;
    #1; check("rd_in_reset", read_data, 32'h0);
    step();
    write_enable = 1'b0;
    reset = 1'b1;
    #1; check("we_in_reset", read_data, 32'h2);

    // Randomised memory and PC traffic against the model
    pc_m = pc_reg;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] addr;
      int unsigned mi;
      addr = {$urandom_range(0, 3) == 0 ? 22'($urandom) : 22'h0, 10'($urandom)};
      mi = addr[9:2];
      address = addr;
      write_enable = $urandom_range(0, 1) == 1;
      read_enable  = $urandom_range(0, 3) != 0;
      write_data = $urandom;
      pcnext = $urandom_range(0, 1) == 1;
      pc_load = $urandom_range(0, 5) == 0;
      pc_target = $urandom;
      #1;
      check("rand_rd_pre", read_data, read_enable ? mem_m[mi] : 32'h0);
      step();
      if (write_enable) mem_m[mi] = write_data;
      if (pc_load) pc_m = pc_target & 32'hFFFF_FFFC;
      else if (pcnext) pc_m = pc_m + 32'd4;
      check("rand_rd_post", read_data, read_enable ? mem_m[mi] : 32'h0);
      check("rand_pc", pc_reg, pc_m);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
